decode_execute_stage: RTL and testbench

Pipelined decode-to-execute stage of the Y86-64 processor. It sits directly downstream of the register file. It derives `d_srcA`, `d_srcB`, `d_dstE` and `d_dstM` from the D-stage instruction fields and drives the source IDs to the register file read ports. It resolves `valA`/`valB` through the forwarding network, detects load/use hazards, and latches the result into the E pipeline register, inserting bubbles when required.

---
 rtl/decode_execute_stage.sv | 185 ++++++++++++++++++
 tb/tb_decode_execute_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_execute_stage.sv
// Y86-64 decode stage: register IDs, operand forwarding, load/use detection,
// and the E pipeline register.
module decode_execute_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       D_stat,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       D_ifun,
    input  logic [3:0]       D_rA,
    input  logic [3:0]       D_rB,
    input  logic [WIDTH-1:0] D_valC,
    input  logic [WIDTH-1:0] D_valP,
    output logic [3:0]       d_srcA,
    output logic [3:0]       d_srcB,
    input  logic [WIDTH-1:0] d_rvalA,
    input  logic [WIDTH-1:0] d_rvalB,
    input  logic [3:0]       e_dstE,
    input  logic [WIDTH-1:0] e_valE,
    input  logic [3:0]       M_dstE,
    input  logic [WIDTH-1:0] M_valE,
    input  logic [3:0]       M_dstM,
    input  logic [WIDTH-1:0] m_valM,
    input  logic [3:0]       W_dstE,
    input  logic [WIDTH-1:0] W_valE,
    input  logic [3:0]       W_dstM,
    input  logic [WIDTH-1:0] W_valM,
    input  logic             e_bubble,
    output logic             d_stall,
    output logic [1:0]       E_stat,
    output logic [3:0]       E_icode,
    output logic [3:0]       E_ifun,
    output logic [WIDTH-1:0] E_valC,
    output logic [WIDTH-1:0] E_valA,
    output logic [WIDTH-1:0] E_valB,
    output logic [3:0]       E_dstE,
    output logic [3:0]       E_dstM,
    output logic [3:0]       E_srcA,
    output logic [3:0]       E_srcB
);

    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] RRMOVQ = 4'h2;
    localparam logic [3:0] IRMOVQ = 4'h3;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;
    localparam logic [3:0] RSP    = 4'h4;
    localparam logic [3:0] RNONE  = 4'hF;

    logic [3:0]       srcA;
    logic [3:0]       srcB;
    logic [3:0]       dstE;
    logic [3:0]       dstM;
    logic [WIDTH-1:0] valA;
    logic [WIDTH-1:0] valB;
    logic             loadUse;
    logic             bubble;

    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (D_icode)
            RRMOVQ: begin
                srcA = D_rA;
                dstE = D_rB;
            end
            IRMOVQ: dstE = D_rB;
            RMMOVQ: begin
                srcA = D_rA;
                srcB = D_rB;
            end
            MRMOVQ: begin
                srcB = D_rB;
                dstM = D_rA;
            end
            OPQ: begin
                srcA = D_rA;
                srcB = D_rB;
                dstE = D_rB;
            end
            CALL: begin
                srcB = RSP;
                dstE = RSP;
            end
            RET: begin
                srcA = RSP;
                srcB = RSP;
                dstE = RSP;
            end
            PUSHQ: begin
                srcA = D_rA;
                srcB = RSP;
                dstE = RSP;
            end
            POPQ: begin
                srcA = RSP;
                srcB = RSP;
                dstE = RSP;
                dstM = D_rA;
            end
            default: ;
        endcase
    end

    assign d_srcA = srcA;
    assign d_srcB = srcB;

    // RNONE is masked so a candidate with no destination never forwards
    always_comb begin
        valA = d_rvalA;
        if (D_icode == CALL || D_icode == JXX)
            valA = D_valP;
        else if (srcA != RNONE) begin
            if (e_dstE == srcA)      valA = e_valE;
            else if (M_dstM == srcA) valA = m_valM;
            else if (M_dstE == srcA) valA = M_valE;
            else if (W_dstM == srcA) valA = W_valM;
            else if (W_dstE == srcA) valA = W_valE;
        end
    end

    always_comb begin
        valB = d_rvalB;
        if (srcB != RNONE) begin
            if (e_dstE == srcB)      valB = e_valE;
            else if (M_dstM == srcB) valB = m_valM;
            else if (M_dstE == srcB) valB = M_valE;
            else if (W_dstM == srcB) valB = W_valM;
            else if (W_dstE == srcB) valB = W_valE;
        end
    end

    assign loadUse = (E_icode == MRMOVQ || E_icode == POPQ)
                   && (E_dstM != RNONE)
                   && (E_dstM == srcA || E_dstM == srcB);
    assign d_stall = loadUse;
    assign bubble  = e_bubble | loadUse;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            E_stat  <= 2'd0;
            E_icode <= NOP;
            E_ifun  <= 4'h0;
            E_valC  <= '0;
            E_valA  <= '0;
            E_valB  <= '0;
            E_dstE  <= RNONE;
            E_dstM  <= RNONE;
            E_srcA  <= RNONE;
            E_srcB  <= RNONE;
        end else if (bubble) begin
            E_stat  <= 2'd0;
            E_icode <= NOP;
            E_ifun  <= 4'h0;
            E_valC  <= '0;
            E_valA  <= '0;
            E_valB  <= '0;
            E_dstE  <= RNONE;
            E_dstM  <= RNONE;
            E_srcA  <= RNONE;
            E_srcB  <= RNONE;
        end else begin
            E_stat  <= D_stat;
            E_icode <= D_icode;
            E_ifun  <= D_ifun;
            E_valC  <= D_valC;
            E_valA  <= valA;
            E_valB  <= valB;
            E_dstE  <= dstE;
            E_dstM  <= dstM;
            E_srcA  <= srcA;
            E_srcB  <= srcB;
        end
    end

endmodule

// File: tb/tb_decode_execute_stage.sv
// Directed bench for decode_execute_stage: vector table plus
// hand-written load/use, bubble and reset sequences.
module tb_decode_execute_stage;

    logic        clock;
    logic        reset;
    logic [1:0]  D_stat;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic [3:0]  d_srcA, d_srcB;
    logic [63:0] d_rvalA, d_rvalB;
    logic [3:0]  e_dstE;
    logic [63:0] e_valE;
    logic [3:0]  M_dstE, M_dstM;
    logic [63:0] M_valE, m_valM;
    logic [3:0]  W_dstE, W_dstM;
    logic [63:0] W_valE, W_valM;
    logic        e_bubble;
    logic        d_stall;
    logic [1:0]  E_stat;
    logic [3:0]  E_icode, E_ifun;
    logic [63:0] E_valC, E_valA, E_valB;
    logic [3:0]  E_dstE, E_dstM, E_srcA, E_srcB;

    int total = 0;
    int passed = 0;

    decode_execute_stage dut (
        .clock(clock), .reset(reset),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
        .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP),
        .d_srcA(d_srcA), .d_srcB(d_srcB),
        .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstE(M_dstE), .M_valE(M_valE),
        .M_dstM(M_dstM), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_valE(W_valE),
        .W_dstM(W_dstM), .W_valM(W_valM),
        .e_bubble(e_bubble), .d_stall(d_stall),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM),
        .E_srcA(E_srcA), .E_srcB(E_srcB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  stat;
        logic [3:0]  icode, ifun, rA, rB;
        logic [63:0] valC, valP, rvalA, rvalB;
        logic [3:0]  eDstE;
        logic [63:0] eValE;
        logic [3:0]  mDstE;
        logic [63:0] mValE;
        logic [3:0]  mDstM;
        logic [63:0] mValM;
        logic [3:0]  wDstE;
        logic [63:0] wValE;
        logic [3:0]  wDstM;
        logic [63:0] wValM;
        logic        eBub;
        logic [3:0]  xSrcA, xSrcB;
        logic        xStall;
        logic [63:0] xValA, xValB;
        logic [3:0]  xDstE, xDstM;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic setIdle();
        d_rvalA = 0; d_rvalB = 0;
        e_dstE = 4'hF; e_valE = 0;
        M_dstE = 4'hF; M_valE = 0;
        M_dstM = 4'hF; m_valM = 0;
        W_dstE = 4'hF; W_valE = 0;
        W_dstM = 4'hF; W_valM = 0;
        e_bubble = 1'b0;
    endtask

    task automatic setD(input logic [1:0] s, input logic [3:0] ic,
                        input logic [3:0] fn, input logic [3:0] a,
                        input logic [3:0] b, input logic [63:0] c,
                        input logic [63:0] p);
        D_stat = s; D_icode = ic; D_ifun = fn;
        D_rA = a; D_rB = b; D_valC = c; D_valP = p;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chkBubble(input string tag);
        chk({tag, "_stat"}, 64'(E_stat), 64'd0);
        chk({tag, "_icode"}, 64'(E_icode), 64'd1);
        chk({tag, "_ifun"}, 64'(E_ifun), 64'd0);
        chk({tag, "_valC"}, E_valC, 64'd0);
        chk({tag, "_valA"}, E_valA, 64'd0);
        chk({tag, "_valB"}, E_valB, 64'd0);
        chk({tag, "_dstE"}, 64'(E_dstE), 64'hF);
        chk({tag, "_dstM"}, 64'(E_dstM), 64'hF);
        chk({tag, "_srcA"}, 64'(E_srcA), 64'hF);
        chk({tag, "_srcB"}, 64'(E_srcB), 64'hF);
    endtask

    initial begin
        // stat icode ifun rA rB valC valP rvalA rvalB
        // eDstE eValE mDstE mValE mDstM mValM wDstE wValE wDstM wValM
        // eBub | xSrcA xSrcB xStall xValA xValB xDstE xDstM
        vecs[0]  = '{0, 6, 0, 2, 3, 0, 0, 0, 'h44,
                     2, 'h11, 2, 'h22, 15, 0, 15, 0, 3, 'h33,
                     0, 2, 3, 0, 'h11, 'h33, 3, 15};
        vecs[1]  = '{0, 6, 1, 5, 6, 0, 0, 1, 2,
                     15, 0, 5, 'hA2, 5, 'hA1, 6, 'hB1, 6, 'hB2,
                     0, 5, 6, 0, 'hA1, 'hB2, 6, 15};
        vecs[2]  = '{0, 2, 3, 7, 8, 0, 0, 3, 0,
                     15, 0, 7, 'hC1, 15, 0, 15, 0, 7, 'hC2,
                     0, 7, 15, 0, 'hC1, 0, 8, 15};
        vecs[3]  = '{0, 4, 0, 9, 10, 'h18, 0, 5, 'hD2,
                     15, 0, 15, 0, 15, 0, 9, 'hD1, 15, 0,
                     0, 9, 10, 0, 'hD1, 'hD2, 15, 15};
        vecs[4]  = '{0, 8, 0, 15, 15, 'h400, 'h100, 0, 'h200,
                     15, 'h55, 15, 0, 15, 0, 15, 0, 15, 0,
                     0, 15, 4, 0, 'h100, 'h200, 4, 15};
        vecs[5]  = '{0, 3, 0, 15, 3, 'h1234, 0, 0, 0,
                     15, 'h99, 15, 'h98, 15, 'h97, 15, 'h96, 15, 'h95,
                     0, 15, 15, 0, 0, 0, 3, 15};
        vecs[6]  = '{0, 11, 0, 3, 15, 0, 0, 'h300, 'h300,
                     4, 'h308, 15, 0, 15, 0, 15, 0, 15, 0,
                     0, 4, 4, 0, 'h308, 'h308, 4, 3};
        vecs[7]  = '{0, 5, 0, 1, 2, 8, 0, 0, 'h70,
                     15, 0, 15, 0, 3, 'hEE, 15, 0, 15, 0,
                     0, 15, 2, 0, 0, 'h70, 15, 1};
        vecs[8]  = '{0, 10, 0, 6, 15, 0, 0, 6, 'h80,
                     15, 0, 15, 0, 15, 0, 15, 0, 15, 0,
                     1, 6, 4, 0, 0, 0, 15, 15};
        vecs[9]  = '{0, 7, 2, 15, 15, 'h80, 'h40, 0, 0,
                     15, 0, 15, 0, 15, 0, 15, 0, 15, 0,
                     0, 15, 15, 0, 'h40, 0, 15, 15};
        vecs[10] = '{1, 0, 0, 2, 3, 0, 0, 0, 0,
                     15, 0, 15, 0, 15, 0, 15, 0, 15, 0,
                     0, 15, 15, 0, 0, 0, 15, 15};
        vecs[11] = '{2, 9, 0, 15, 15, 0, 0, 'h10, 'h10,
                     15, 0, 15, 0, 15, 0, 4, 'h18, 15, 0,
                     0, 4, 4, 0, 'h18, 'h18, 4, 15};
        vecs[12] = '{3, 12, 0, 1, 2, 0, 0, 0, 0,
                     15, 0, 15, 0, 15, 0, 15, 0, 15, 0,
                     0, 15, 15, 0, 0, 0, 15, 15};

        // asynchronous reset with live D inputs
        reset = 1'b1;
        setIdle();
        setD(2'd1, 4'h6, 4'h2, 4'h2, 4'h3, 64'h77, 64'h88);
        d_rvalA = 64'h5; d_rvalB = 64'h6;
        #2 reset = 1'b0;
        #1 chkBubble("rst_async");
        step();
        chkBubble("rst_edge");
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            vec_t v;
            logic bub;
            string t;
            v = vecs[i];
            t = $sformatf("v%0d", i);
            @(negedge clock);
            setD(v.stat, v.icode, v.ifun, v.rA, v.rB, v.valC, v.valP);
            d_rvalA = v.rvalA; d_rvalB = v.rvalB;
            e_dstE = v.eDstE; e_valE = v.eValE;
            M_dstE = v.mDstE; M_valE = v.mValE;
            M_dstM = v.mDstM; m_valM = v.mValM;
            W_dstE = v.wDstE; W_valE = v.wValE;
            W_dstM = v.wDstM; W_valM = v.wValM;
            e_bubble = v.eBub;
            #1;
            chk({t, "_d_srcA"}, 64'(d_srcA), 64'(v.xSrcA));
            chk({t, "_d_srcB"}, 64'(d_srcB), 64'(v.xSrcB));
            chk({t, "_d_stall"}, 64'(d_stall), 64'(v.xStall));
            step();
            bub = v.eBub | v.xStall;
            if (bub) chkBubble(t);
            else begin
                chk({t, "_stat"}, 64'(E_stat), 64'(v.stat));
                chk({t, "_icode"}, 64'(E_icode), 64'(v.icode));
                chk({t, "_ifun"}, 64'(E_ifun), 64'(v.ifun));
                chk({t, "_valC"}, E_valC, v.valC);
                chk({t, "_valA"}, E_valA, v.xValA);
                chk({t, "_valB"}, E_valB, v.xValB);
                chk({t, "_dstE"}, 64'(E_dstE), 64'(v.xDstE));
                chk({t, "_dstM"}, 64'(E_dstM), 64'(v.xDstM));
                chk({t, "_srcA"}, 64'(E_srcA), 64'(v.xSrcA));
                chk({t, "_srcB"}, 64'(E_srcB), 64'(v.xSrcB));
            end
        end

        // load/use on srcA, then forward from m_valM
        @(negedge clock);
        setIdle();
        setD(2'd0, 4'h5, 4'h0, 4'h1, 4'h2, 64'h0, 64'h0);
        step();
        @(negedge clock);
        setD(2'd0, 4'h6, 4'h0, 4'h1, 4'h3, 64'h0, 64'h0);
        d_rvalA = 64'h5;
        #1 chk("lu_stall", 64'(d_stall), 64'd1);
        step();
        chkBubble("lu_bub");
        chk("lu_release", 64'(d_stall), 64'd0);
        @(negedge clock);
        M_dstM = 4'h1; m_valM = 64'hAB;
        step();
        chk("lu_valA", E_valA, 64'hAB);
        chk("lu_icode", 64'(E_icode), 64'h6);
        chk("lu_dstE", 64'(E_dstE), 64'h3);

        // POPQ in E hazards on srcB
        @(negedge clock);
        setIdle();
        setD(2'd0, 4'hB, 4'h0, 4'h5, 4'hF, 64'h0, 64'h0);
        step();
        @(negedge clock);
        setD(2'd0, 4'h6, 4'h0, 4'h2, 4'h5, 64'h0, 64'h0);
        #1 chk("lu_srcB_stall", 64'(d_stall), 64'd1);
        step();
        chk("lu_srcB_bub", 64'(E_icode), 64'h1);

        // load with dstM=RNONE never stalls an RNONE source
        @(negedge clock);
        setD(2'd0, 4'h5, 4'h0, 4'hF, 4'h2, 64'h0, 64'h0);
        step();
        @(negedge clock);
        setD(2'd0, 4'h3, 4'h0, 4'hF, 4'h3, 64'h9, 64'h0);
        #1 chk("lu_rnone_stall", 64'(d_stall), 64'd0);
        step();
        chk("lu_rnone_icode", 64'(E_icode), 64'h3);

        // e_bubble coincident with load/use
        @(negedge clock);
        setD(2'd0, 4'h5, 4'h0, 4'h1, 4'h2, 64'h0, 64'h0);
        step();
        @(negedge clock);
        setD(2'd0, 4'h6, 4'h0, 4'h1, 4'h3, 64'h0, 64'h0);
        e_bubble = 1'b1;
        #1 chk("both_stall", 64'(d_stall), 64'd1);
        step();
        chkBubble("both_bub");
        @(negedge clock);
        e_bubble = 1'b0;
        #1 chk("both_nostall", 64'(d_stall), 64'd0);
        step();
        chk("both_icode", 64'(E_icode), 64'h6);
        chk("both_srcA", 64'(E_srcA), 64'h1);

        // reset asserted mid-stall
        @(negedge clock);
        setD(2'd0, 4'h5, 4'h0, 4'h1, 4'h2, 64'h0, 64'h0);
        step();
        @(negedge clock);
        setD(2'd0, 4'h6, 4'h0, 4'h1, 4'h3, 64'h0, 64'h0);
        #1 chk("mid_stall", 64'(d_stall), 64'd1);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_icode", 64'(E_icode), 64'h1);
        chk("mid_rst_dstM", 64'(E_dstM), 64'hF);
        chk("mid_rst_stall", 64'(d_stall), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        step();
        chk("mid_rst_load", 64'(E_icode), 64'h6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
